// File: rtl/tx_ser_pkg.sv
// Shared types and constants for the word serializer and its bit timer.
package tx_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_ser_state_t;

  localparam int   DEF_WORD_W = 32;
  localparam int   BIT_IDX_W  = $clog2(DEF_WORD_W);
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic START_LVL  = 1'b0;

endpackage

// File: rtl/tx_bit_timer.sv
// Fixed clock divider: one bit_tick every CLKS_PER_BIT clocks, restartable via clear.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_clk_cnt;

  assign o_bit_tick = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Count 0..CLKS_PER_BIT-1; a clear (state change) restarts the bit period at 0.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_clk_cnt <= '0;
    end else if (i_clear || o_bit_tick) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_word_serializer.sv
// Pops words from tx_fifo and sends each as start bit, MSB-first data, stop bit.
module tx_word_serializer
  import tx_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int WORD_W       = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_en,
  input  logic [WORD_W-1:0] fifo_out,
  input  logic              fifo_empty,
  output logic              tx_deq_word,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done
);

  tx_ser_state_t          r_state;
  tx_ser_state_t          w_state_next;
  logic [WORD_W-1:0]      r_shift;
  logic [WORD_W-1:0]      w_shift_next;
  logic [BIT_IDX_W-1:0]   r_bit_idx;
  logic [BIT_IDX_W-1:0]   w_bit_idx_next;
  logic                   r_serial;
  logic                   w_serial_next;
  logic                   w_bit_tick;
  logic                   w_clear;
  logic                   w_can_start;
  logic                   w_last_bit;

  assign w_can_start = tx_en && !fifo_empty;
  assign w_last_bit  = (r_bit_idx == BIT_IDX_W'(WORD_W - 1));

  // Idle holds the divider at zero so every START begins a fresh bit period.
  assign w_clear = (w_state_next != r_state) || (r_state == IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_clear   (w_clear),
    .o_bit_tick(w_bit_tick)
  );

  // Next-state, shift register and bit index; the line level follows the next state.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (w_can_start) w_state_next = LOAD;
      end
      LOAD: begin
        w_shift_next = fifo_out;
        w_state_next = START;
      end
      START: begin
        if (w_bit_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shift_next = {r_shift[WORD_W-2:0], 1'b0};
          if (w_last_bit) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_tick) w_state_next = w_can_start ? LOAD : IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    case (w_state_next)
      START:   w_serial_next = START_LVL;
      DATA:    w_serial_next = w_shift_next[WORD_W-1];
      default: w_serial_next = LINE_IDLE;
    endcase
  end

  // State, data and line register; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_serial  <= LINE_IDLE;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_serial  <= w_serial_next;
    end
  end

  assign tx_serial   = r_serial;
  assign tx_deq_word = (r_state == LOAD);
  assign tx_busy     = (r_state != IDLE);
  assign frame_done  = (r_state == STOP) && w_bit_tick;

endmodule
